seq_control: RTL and testbench



---
 rtl/seq_pkg.sv | 23 ++
 rtl/seq_control_if.sv | 27 ++
 rtl/seq_step_counter.sv | 91 +++++++++
 rtl/seq_control.sv | 155 +++++++++++++++
 tb/tb_seq_control.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared types and helpers for the drum-machine sequencer controller.
package seq_pkg;

    typedef enum logic [2:0] {
        S_LOAD_BPM      = 3'd0,
        S_LOAD_BPM_WAIT = 3'd1,
        S_LOAD_CH       = 3'd2,
        S_LOAD_CH_WAIT  = 3'd3,
        S_PLAY          = 3'd4,
        S_IDLE          = 3'd5,
        S_IDLE_WAIT     = 3'd6
    } seq_state_e;

    // Next beat position: wraps back to step 1 after the last step; an out-of-range value also wraps.
    function automatic int unsigned wrap_next_step(input int unsigned cur, input int unsigned num_steps);
        if (cur >= num_steps) begin
            return 32'd1;
        end else begin
            return cur + 32'd1;
        end
    endfunction

endpackage

// File: rtl/seq_control_if.sv
// Button/tempo inputs and load/step outputs of the sequencer controller.
interface seq_control_if #(
    parameter int NUM_CH = 4,
    parameter int STEP_W = 4,
    parameter int BAR_W  = 8
);
    logic              go;
    logic              stop;
    logic              step_tick;
    logic              ld_bpm;
    logic [NUM_CH-1:0] ld_ch;
    logic              play;
    logic [STEP_W-1:0] timing;
    logic              step_pulse;
    logic              bar_pulse;
    logic [BAR_W-1:0]  bar_count;

    modport master (
        output go, stop, step_tick,
        input  ld_bpm, ld_ch, play, timing, step_pulse, bar_pulse, bar_count
    );

    modport slave (
        input  go, stop, step_tick,
        output ld_bpm, ld_ch, play, timing, step_pulse, bar_pulse, bar_count
    );
endinterface

// File: rtl/seq_step_counter.sv
// Beat/bar counter: advances one step per tick while enabled, reports bar wraps
// and signals when the configured number of bars has been played.
module seq_step_counter
    import seq_pkg::*;
#(
    parameter int NUM_STEPS = 8,
    parameter int BARS      = 0,
    parameter int STEP_W    = $clog2(NUM_STEPS + 1),
    parameter int BAR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              tick,
    input  logic              clear,
    output logic [STEP_W-1:0] timing,
    output logic              step_pulse,
    output logic              bar_pulse,
    output logic [BAR_W-1:0]  bar_count,
    output logic              bars_done
);
    localparam bit AUTO_STOP = (BARS > 0);

    logic [STEP_W-1:0] timing_r;
    logic              step_pulse_r;
    logic              bar_pulse_r;
    logic [BAR_W-1:0]  bar_count_r;
    logic              at_end_s;
    logic              wrap_s;
    logic [BAR_W-1:0]  bar_next_s;
    logic [STEP_W-1:0] step_next_s;
    logic              bars_done_s;

    // Wrap detection and the bar-limit compare that the FSM needs on the same edge.
    always_comb begin
        at_end_s    = (timing_r == STEP_W'(NUM_STEPS));
        wrap_s      = enable && tick && at_end_s;
        bar_next_s  = bar_count_r + BAR_W'(1);
        step_next_s = STEP_W'(wrap_next_step(32'(timing_r), NUM_STEPS));
        if (AUTO_STOP && wrap_s && (bar_next_s == BAR_W'(BARS))) begin
            bars_done_s = 1'b1;
        end else begin
            bars_done_s = 1'b0;
        end
    end

    // Step/bar state; a disabled counter parks at timing 0 but keeps bar_count until cleared.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timing_r     <= '0;
            step_pulse_r <= 1'b0;
            bar_pulse_r  <= 1'b0;
            bar_count_r  <= '0;
        end else if (clear) begin
            timing_r     <= '0;
            step_pulse_r <= 1'b0;
            bar_pulse_r  <= 1'b0;
            bar_count_r  <= '0;
        end else if (!enable) begin
            timing_r     <= '0;
            step_pulse_r <= 1'b0;
            bar_pulse_r  <= 1'b0;
        end else if (tick) begin
            if (bars_done_s) begin
                timing_r     <= '0;
                step_pulse_r <= 1'b0;
                bar_pulse_r  <= 1'b1;
                bar_count_r  <= bar_next_s;
            end else if (at_end_s) begin
                timing_r     <= step_next_s;
                step_pulse_r <= 1'b1;
                bar_pulse_r  <= 1'b1;
                bar_count_r  <= bar_next_s;
            end else begin
                timing_r     <= step_next_s;
                step_pulse_r <= 1'b1;
                bar_pulse_r  <= 1'b0;
            end
        end else begin
            step_pulse_r <= 1'b0;
            bar_pulse_r  <= 1'b0;
        end
    end

    assign timing     = timing_r;
    assign step_pulse = step_pulse_r;
    assign bar_pulse  = bar_pulse_r;
    assign bar_count  = bar_count_r;
    assign bars_done  = bars_done_s;

endmodule

// File: rtl/seq_control.sv
// Sequencer controller: button-driven BPM/pattern load phase, then play/idle
// control of the beat counter with optional auto-stop after BARS bars.
module seq_control
    import seq_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int NUM_STEPS = 8,
    parameter int BARS      = 0,
    parameter int STEP_W    = $clog2(NUM_STEPS + 1),
    parameter int BAR_W     = 8
) (
    input logic          clk,
    input logic          reset,
    seq_control_if.slave bus
);
    localparam int                CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [NUM_CH-1:0] CH_ONE  = NUM_CH'(1);
    localparam logic [CH_W-1:0]   CH_LAST = CH_W'(NUM_CH - 1);

    seq_state_e        state_r;
    logic [CH_W-1:0]   ch_idx_r;
    logic              ld_bpm_r;
    logic [NUM_CH-1:0] ld_ch_r;
    logic              play_r;
    logic              last_ch_s;
    logic              clear_s;
    logic              cnt_enable_s;
    logic              bars_done_s;
    logic [STEP_W-1:0] timing_s;
    logic              step_pulse_s;
    logic              bar_pulse_s;
    logic [BAR_W-1:0]  bar_count_s;

    // Counter control: bar_count restarts whenever play is (re)entered; stop beats a coincident tick.
    always_comb begin
        last_ch_s = (ch_idx_r == CH_LAST);
        if ((state_r == S_IDLE_WAIT) && !bus.go) begin
            clear_s = 1'b1;
        end else if ((state_r == S_LOAD_CH_WAIT) && !bus.go && last_ch_s) begin
            clear_s = 1'b1;
        end else begin
            clear_s = 1'b0;
        end
        cnt_enable_s = (state_r == S_PLAY) && !bus.stop;
    end

    // Main FSM; load enables and play are registered from the next state so they track state exactly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= S_LOAD_BPM;
            ch_idx_r <= '0;
            ld_bpm_r <= 1'b1;
            ld_ch_r  <= '0;
            play_r   <= 1'b0;
        end else begin
            ld_bpm_r <= 1'b0;
            ld_ch_r  <= '0;
            play_r   <= 1'b0;
            case (state_r)
                S_LOAD_BPM: begin
                    if (bus.go) begin
                        state_r <= S_LOAD_BPM_WAIT;
                    end else begin
                        state_r  <= S_LOAD_BPM;
                        ld_bpm_r <= 1'b1;
                    end
                end
                S_LOAD_BPM_WAIT: begin
                    if (!bus.go) begin
                        state_r  <= S_LOAD_CH;
                        ch_idx_r <= '0;
                        ld_ch_r  <= CH_ONE;
                    end else begin
                        state_r <= S_LOAD_BPM_WAIT;
                    end
                end
                S_LOAD_CH: begin
                    if (bus.go) begin
                        state_r <= S_LOAD_CH_WAIT;
                    end else begin
                        state_r <= S_LOAD_CH;
                        ld_ch_r <= CH_ONE << ch_idx_r;
                    end
                end
                S_LOAD_CH_WAIT: begin
                    if (bus.go) begin
                        state_r <= S_LOAD_CH_WAIT;
                    end else if (last_ch_s) begin
                        state_r <= S_PLAY;
                        play_r  <= 1'b1;
                    end else begin
                        state_r  <= S_LOAD_CH;
                        ch_idx_r <= ch_idx_r + CH_W'(1);
                        ld_ch_r  <= CH_ONE << (ch_idx_r + CH_W'(1));
                    end
                end
                S_PLAY: begin
                    if (bus.stop || bars_done_s) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_PLAY;
                        play_r  <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (bus.go) begin
                        state_r <= S_IDLE_WAIT;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_IDLE_WAIT: begin
                    if (!bus.go) begin
                        state_r <= S_PLAY;
                        play_r  <= 1'b1;
                    end else begin
                        state_r <= S_IDLE_WAIT;
                    end
                end
                default: begin
                    state_r  <= S_LOAD_BPM;
                    ch_idx_r <= '0;
                    ld_bpm_r <= 1'b1;
                end
            endcase
        end
    end

    seq_step_counter #(
        .NUM_STEPS (NUM_STEPS),
        .BARS      (BARS),
        .STEP_W    (STEP_W),
        .BAR_W     (BAR_W)
    ) u_step_counter (
        .clk        (clk),
        .reset      (reset),
        .enable     (cnt_enable_s),
        .tick       (bus.step_tick),
        .clear      (clear_s),
        .timing     (timing_s),
        .step_pulse (step_pulse_s),
        .bar_pulse  (bar_pulse_s),
        .bar_count  (bar_count_s),
        .bars_done  (bars_done_s)
    );

    assign bus.ld_bpm     = ld_bpm_r;
    assign bus.ld_ch      = ld_ch_r;
    assign bus.play       = play_r;
    assign bus.timing     = timing_s;
    assign bus.step_pulse = step_pulse_s;
    assign bus.bar_pulse  = bar_pulse_s;
    assign bus.bar_count  = bar_count_s;

endmodule

// File: tb/tb_seq_control.sv
// Directed bench: dut_a loops forever (NUM_CH=4, NUM_STEPS=8), dut_b auto-stops (NUM_CH=1, NUM_STEPS=4, BARS=2).
module tb_seq_control;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    seq_control_if #(.NUM_CH(4), .STEP_W(4), .BAR_W(8)) bus_a ();
    seq_control_if #(.NUM_CH(1), .STEP_W(3), .BAR_W(8)) bus_b ();

    seq_control #(.NUM_CH(4), .NUM_STEPS(8), .BARS(0), .STEP_W(4), .BAR_W(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    seq_control #(.NUM_CH(1), .NUM_STEPS(4), .BARS(2), .STEP_W(3), .BAR_W(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_a();
        bus_a.step_tick = 1'b1;
        cyc(1);
        bus_a.step_tick = 1'b0;
    endtask

    task automatic press_a();
        bus_a.go = 1'b1;
        cyc(1);
        bus_a.go = 1'b0;
        cyc(1);
    endtask

    initial begin
        logic [2:0] tim_b [0:8];
        logic       sp_b  [0:8];
        logic       bp_b  [0:8];
        logic [7:0] bc_b  [0:8];
        logic       pl_b  [0:8];
        tim_b = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        sp_b  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bp_b  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        bc_b  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2};
        pl_b  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        reset = 1'b0;
        bus_a.go = 1'b0; bus_a.stop = 1'b0; bus_a.step_tick = 1'b0;
        bus_b.go = 1'b0; bus_b.stop = 1'b0; bus_b.step_tick = 1'b0;
        cyc(2);
        chk("rst_ld_bpm", 32'(bus_a.ld_bpm), 32'd1);
        chk("rst_ld_ch", 32'(bus_a.ld_ch), 32'd0);
        chk("rst_play", 32'(bus_a.play), 32'd0);
        chk("rst_timing", 32'(bus_a.timing), 32'd0);
        chk("rst_bar_count", 32'(bus_a.bar_count), 32'd0);
        chk("rst_pulses", 32'({bus_a.step_pulse, bus_a.bar_pulse}), 32'd0);
        reset = 1'b1;
        cyc(1);
        chk("post_rst_ld_bpm", 32'(bus_a.ld_bpm), 32'd1);

        // go held for 10 cycles advances only once
        bus_a.go = 1'b1;
        cyc(10);
        chk("held_go_ld_bpm", 32'(bus_a.ld_bpm), 32'd0);
        chk("held_go_ld_ch", 32'(bus_a.ld_ch), 32'd0);
        bus_a.go = 1'b0;
        cyc(1);
        chk("load_ch0", 32'(bus_a.ld_ch), 32'h1);
        chk("load_ch0_bpm", 32'(bus_a.ld_bpm), 32'd0);
        for (int k = 1; k < 4; k++) begin
            bus_a.go = 1'b1;
            cyc(1);
            chk("wait_ld_ch", 32'(bus_a.ld_ch), 32'd0);
            bus_a.go = 1'b0;
            cyc(1);
            chk("load_chk", 32'(bus_a.ld_ch), 32'd1 << k);
        end
        bus_a.go = 1'b1;
        cyc(1);
        chk("last_wait_play", 32'(bus_a.play), 32'd0);
        bus_a.go = 1'b0;
        cyc(1);
        chk("enter_play", 32'(bus_a.play), 32'd1);
        chk("enter_timing", 32'(bus_a.timing), 32'd0);
        chk("enter_ld_ch", 32'(bus_a.ld_ch), 32'd0);

        // Nine ticks: 1..8 then wrap to 1 with a bar pulse
        for (int i = 1; i <= 9; i++) begin
            tick_a();
            chk("tick_timing", 32'(bus_a.timing), 32'((i <= 8) ? i : 1));
            chk("tick_step_pulse", 32'(bus_a.step_pulse), 32'd1);
            chk("tick_bar_pulse", 32'(bus_a.bar_pulse), 32'((i == 9) ? 1 : 0));
            cyc(1);
            chk("tick_pulse_drop", 32'({bus_a.step_pulse, bus_a.bar_pulse}), 32'd0);
        end
        chk("bar_count_1", 32'(bus_a.bar_count), 32'd1);

        for (int i = 0; i < 4; i++) begin
            tick_a();
        end
        chk("timing_5", 32'(bus_a.timing), 32'd5);
        bus_a.stop = 1'b1;
        cyc(1);
        bus_a.stop = 1'b0;
        chk("stop_play", 32'(bus_a.play), 32'd0);
        chk("stop_timing", 32'(bus_a.timing), 32'd0);
        chk("stop_bar_count_kept", 32'(bus_a.bar_count), 32'd1);
        tick_a();
        chk("idle_tick_timing", 32'(bus_a.timing), 32'd0);
        chk("idle_tick_pulse", 32'(bus_a.step_pulse), 32'd0);
        bus_a.go = 1'b1;
        cyc(1);
        chk("idle_wait_play", 32'(bus_a.play), 32'd0);
        bus_a.go = 1'b0;
        cyc(1);
        chk("resume_play", 32'(bus_a.play), 32'd1);
        chk("resume_timing", 32'(bus_a.timing), 32'd0);
        chk("resume_bar_count", 32'(bus_a.bar_count), 32'd0);
        chk("resume_no_load", 32'({bus_a.ld_bpm, bus_a.ld_ch}), 32'd0);
        tick_a();
        chk("resume_tick_timing", 32'(bus_a.timing), 32'd1);
        tick_a();
        tick_a();
        chk("timing_3", 32'(bus_a.timing), 32'd3);

        // stop and tick together: stop wins
        bus_a.stop = 1'b1;
        bus_a.step_tick = 1'b1;
        cyc(1);
        bus_a.stop = 1'b0;
        bus_a.step_tick = 1'b0;
        chk("stop_tick_pulse", 32'(bus_a.step_pulse), 32'd0);
        chk("stop_tick_timing", 32'(bus_a.timing), 32'd0);
        chk("stop_tick_play", 32'(bus_a.play), 32'd0);

        // Auto-stop configuration
        bus_b.go = 1'b1;
        cyc(1);
        chk("b_wait_ld_bpm", 32'(bus_b.ld_bpm), 32'd0);
        bus_b.go = 1'b0;
        cyc(1);
        chk("b_load_ch0", 32'(bus_b.ld_ch), 32'd1);
        bus_b.go = 1'b1;
        cyc(1);
        bus_b.go = 1'b0;
        cyc(1);
        chk("b_enter_play", 32'(bus_b.play), 32'd1);
        for (int i = 0; i < 9; i++) begin
            bus_b.step_tick = 1'b1;
            cyc(1);
            bus_b.step_tick = 1'b0;
            chk("b_timing", 32'(bus_b.timing), 32'(tim_b[i]));
            chk("b_step_pulse", 32'(bus_b.step_pulse), 32'(sp_b[i]));
            chk("b_bar_pulse", 32'(bus_b.bar_pulse), 32'(bp_b[i]));
            chk("b_bar_count", 32'(bus_b.bar_count), 32'(bc_b[i]));
            chk("b_play", 32'(bus_b.play), 32'(pl_b[i]));
        end
        bus_b.step_tick = 1'b1;
        cyc(1);
        bus_b.step_tick = 1'b0;
        chk("b_extra_tick", 32'({bus_b.play, bus_b.timing, bus_b.step_pulse, bus_b.bar_pulse}), 32'd0);
        chk("b_extra_bar_count", 32'(bus_b.bar_count), 32'd2);

        // Mid-play reset on dut_a
        press_a();
        chk("a_resume2_play", 32'(bus_a.play), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick_a();
        end
        chk("a_timing_6", 32'(bus_a.timing), 32'd6);
        reset = 1'b0;
        cyc(1);
        chk("midrst_ld_bpm", 32'(bus_a.ld_bpm), 32'd1);
        chk("midrst_play", 32'(bus_a.play), 32'd0);
        chk("midrst_timing", 32'(bus_a.timing), 32'd0);
        chk("midrst_bar_count", 32'(bus_a.bar_count), 32'd0);
        reset = 1'b1;
        cyc(1);
        chk("post_midrst_ld_bpm", 32'(bus_a.ld_bpm), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
